// File: rtl/trdb_resync_scheduler_if.sv
// Handshake bundle between the trace encoder, the priority module and the resync scheduler.
// Optional late-count port is present only when TRDB_RESYNC_LATE_CNT_EN is defined.
interface trdb_resync_scheduler_if #(
  parameter int COUNTER_W = 16
);
  logic                 trace_enabled_i;
  logic                 packet_emitted_i;
  logic                 mode_valid_i;
  logic                 mode_i;
  logic [COUNTER_W-1:0] threshold_i;
  logic                 force_resync_i;
  logic                 resync_ack_i;
  logic                 resync_req_o;
  logic [COUNTER_W-1:0] count_o;
`ifdef TRDB_RESYNC_LATE_CNT_EN
  logic [COUNTER_W-1:0] late_cnt_o;

  modport master (
    output trace_enabled_i, packet_emitted_i, mode_valid_i, mode_i,
           threshold_i, force_resync_i, resync_ack_i,
    input  resync_req_o, count_o, late_cnt_o
  );

  modport slave (
    input  trace_enabled_i, packet_emitted_i, mode_valid_i, mode_i,
           threshold_i, force_resync_i, resync_ack_i,
    output resync_req_o, count_o, late_cnt_o
  );
`else
  modport master (
    output trace_enabled_i, packet_emitted_i, mode_valid_i, mode_i,
           threshold_i, force_resync_i, resync_ack_i,
    input  resync_req_o, count_o
  );

  modport slave (
    input  trace_enabled_i, packet_emitted_i, mode_valid_i, mode_i,
           threshold_i, force_resync_i, resync_ack_i,
    output resync_req_o, count_o
  );
`endif
endinterface

// File: rtl/trdb_resync_scheduler.sv
// Resync timer: counts cycles or packets against a programmable threshold and holds a
// resync request until acknowledged. TRDB_RESYNC_LATE_CNT_EN adds a late-acknowledge counter.
module trdb_resync_scheduler #(
  parameter int COUNTER_W    = 16,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  trdb_resync_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COUNT   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  localparam logic [COUNTER_W-1:0] CNT_MAX = '1;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [COUNTER_W-1:0] counter;
  logic [COUNTER_W-1:0] counter_next;
  logic                 mode_q;
  logic                 eff_mode;
  logic                 unit;
  logic                 mode_changed;
  logic [COUNTER_W:0]   sum_ext;
  logic [COUNTER_W:0]   thr_ext;
  logic [COUNTER_W-1:0] sum_sat;
  logic                 thr_hit;

  assign eff_mode     = bus.mode_valid_i ? bus.mode_i : DEFAULT_MODE;
  assign unit         = eff_mode ? bus.packet_emitted_i : 1'b1;
  assign mode_changed = (eff_mode != mode_q);

  // One extra bit keeps both the threshold compare and the saturation check free of wrap.
  assign sum_ext = {1'b0, counter} + {{COUNTER_W{1'b0}}, unit};
  assign thr_ext = {1'b0, bus.threshold_i};
  assign sum_sat = sum_ext[COUNTER_W] ? CNT_MAX : sum_ext[COUNTER_W-1:0];
  assign thr_hit = (bus.threshold_i != '0) && (sum_ext >= thr_ext);

  always_comb begin
    state_next   = state;
    counter_next = counter;
    if (!bus.trace_enabled_i) begin
      state_next   = IDLE;
      counter_next = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next   = COUNT;
          counter_next = '0;
        end
        COUNT: begin
          if (bus.force_resync_i) begin
            state_next = PENDING;
          end else if (mode_changed) begin
            counter_next = '0;
          end else if (thr_hit) begin
            state_next = PENDING;
            // A lowered threshold below the current count leaves the count where it was.
            if ({1'b0, counter} < thr_ext) begin
              counter_next = bus.threshold_i;
            end
          end else begin
            counter_next = sum_sat;
          end
        end
        PENDING: begin
          if (bus.resync_ack_i) begin
            state_next   = COUNT;
            counter_next = '0;
          end
        end
        default: begin
          state_next   = IDLE;
          counter_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      counter <= '0;
      mode_q  <= DEFAULT_MODE;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      mode_q  <= eff_mode;
    end
  end

  assign bus.resync_req_o = (state == PENDING);
  assign bus.count_o      = counter;

`ifdef TRDB_RESYNC_LATE_CNT_EN
  logic [COUNTER_W-1:0] late_cnt;
  logic [COUNTER_W-1:0] late_next;
  logic [COUNTER_W:0]   late_sum;

  assign late_sum = {1'b0, late_cnt} + {{COUNTER_W{1'b0}}, unit};

  // Measures how many units slipped by while the request waited; the ack cycle is excluded.
  always_comb begin
    late_next = late_cnt;
    if (!bus.trace_enabled_i || (state == IDLE)) begin
      late_next = '0;
    end else if ((state == COUNT) && (state_next == PENDING)) begin
      late_next = '0;
    end else if ((state == PENDING) && !bus.resync_ack_i) begin
      late_next = late_sum[COUNTER_W] ? CNT_MAX : late_sum[COUNTER_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      late_cnt <= '0;
    end else begin
      late_cnt <= late_next;
    end
  end

  assign bus.late_cnt_o = late_cnt;
`endif

endmodule
